// File: rtl/pkt_tx_arbiter.sv
// Two-source, one-beat packet arbiter feeding a single registered output stage.
// Ties alternate between the diagnostic (dcp) and peripheral (per) sources.
`ifndef PKT_BITS
`define PKT_BITS 72
`endif

module pkt_tx_arbiter #(
  parameter int PKT_BITS  = `PKT_BITS,
  parameter bit DCP_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PKT_BITS-1:0] dcp_data_in,
  input  logic                dcp_vld_in,
  output logic                dcp_rdy_out,
  input  logic [PKT_BITS-1:0] per_data_in,
  input  logic                per_vld_in,
  output logic                per_rdy_out,
  output logic [PKT_BITS-1:0] pkt_data_out,
  output logic                pkt_vld_out,
  input  logic                pkt_rdy_in,
  output logic [1:0]          ptx_cnt_out
);

  typedef enum logic {
    SRC_PER = 1'b0,
    SRC_DCP = 1'b1
  } src_e;

  // Seeding last_src with the opposite source makes the first tie go to the favoured one.
  localparam src_e LAST_SRC_RST = DCP_FIRST ? SRC_PER : SRC_DCP;

  src_e                last_src_q;
  src_e                last_src_d;
  logic                pkt_vld_q;
  logic                pkt_vld_d;
  logic [PKT_BITS-1:0] pkt_data_q;
  logic [PKT_BITS-1:0] pkt_data_d;

  logic load_en_s;
  logic sel_dcp_s;
  logic dcp_xfer_s;
  logic per_xfer_s;

  // Source selection and input handshakes
  always_comb begin
    load_en_s  = 1'b0;
    sel_dcp_s  = 1'b0;
    dcp_xfer_s = 1'b0;
    per_xfer_s = 1'b0;
    if (reset) begin
      load_en_s = 1'b0;
    end else begin
      load_en_s = !pkt_vld_q || pkt_rdy_in;
    end
    case ({dcp_vld_in, per_vld_in})
      2'b11:   sel_dcp_s = (last_src_q == SRC_PER);
      2'b10:   sel_dcp_s = 1'b1;
      2'b01:   sel_dcp_s = 1'b0;
      default: sel_dcp_s = 1'b0;
    endcase
    dcp_xfer_s = load_en_s && dcp_vld_in && sel_dcp_s;
    per_xfer_s = load_en_s && per_vld_in && !sel_dcp_s;
  end

  // Output register and last-source next state
  always_comb begin
    pkt_vld_d  = pkt_vld_q;
    pkt_data_d = pkt_data_q;
    last_src_d = last_src_q;
    if (dcp_xfer_s) begin
      pkt_vld_d  = 1'b1;
      pkt_data_d = dcp_data_in;
      last_src_d = SRC_DCP;
    end else if (per_xfer_s) begin
      pkt_vld_d  = 1'b1;
      pkt_data_d = per_data_in;
      last_src_d = SRC_PER;
    end else if (pkt_rdy_in) begin
      pkt_vld_d  = 1'b0;
    end else begin
      pkt_vld_d  = pkt_vld_q;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_vld_q  <= 1'b0;
      pkt_data_q <= {PKT_BITS{1'b0}};
      last_src_q <= LAST_SRC_RST;
    end else begin
      pkt_vld_q  <= pkt_vld_d;
      pkt_data_q <= pkt_data_d;
      last_src_q <= last_src_d;
    end
  end

  assign dcp_rdy_out  = dcp_xfer_s;
  assign per_rdy_out  = per_xfer_s;
  assign ptx_cnt_out  = {dcp_xfer_s, per_xfer_s};
  assign pkt_vld_out  = pkt_vld_q;
  assign pkt_data_out = pkt_data_q;

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// Self-checking bench: hand-derived vector table plus a reference model with a data scoreboard.
module tb_pkt_tx_arbiter;
  localparam int W = 72;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] dcp_data_in = '0;
  logic         dcp_vld_in = 1'b0;
  logic         dcp_rdy_out;
  logic [W-1:0] per_data_in = '0;
  logic         per_vld_in = 1'b0;
  logic         per_rdy_out;
  logic [W-1:0] pkt_data_out;
  logic         pkt_vld_out;
  logic         pkt_rdy_in = 1'b0;
  logic [1:0]   ptx_cnt_out;

  always #5 clk = ~clk;

  pkt_tx_arbiter #(.PKT_BITS(W), .DCP_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .dcp_data_in(dcp_data_in), .dcp_vld_in(dcp_vld_in), .dcp_rdy_out(dcp_rdy_out),
    .per_data_in(per_data_in), .per_vld_in(per_vld_in), .per_rdy_out(per_rdy_out),
    .pkt_data_out(pkt_data_out), .pkt_vld_out(pkt_vld_out), .pkt_rdy_in(pkt_rdy_in),
    .ptx_cnt_out(ptx_cnt_out)
  );

  typedef struct {
    logic         dv, pv, rin;
    logic [W-1:0] dd, pd;
    logic         edr, epr;
    logic [1:0]   ecnt;
    logic         evld;
    logic [W-1:0] edata;
    logic         cdata;
  } vec_t;

  vec_t tbl[11];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: output register and last granted source (1 = dcp)
  logic [W-1:0] sb_q[$];
  logic         m_vld  = 1'b0;
  logic [W-1:0] m_data = '0;
  logic         m_last = 1'b0;

  function automatic logic [W-1:0] dpk(input int i);
    return 72'hDC_0000_0000_0000_0000 | W'(i);
  endfunction

  function automatic logic [W-1:0] ppk(input int i);
    return 72'h5E_0000_0000_0000_0000 | W'(i);
  endfunction

  function automatic vec_t mk(input logic dv, input logic pv, input logic rin,
                              input logic [W-1:0] dd, input logic [W-1:0] pd,
                              input logic edr, input logic epr, input logic [1:0] ecnt,
                              input logic evld, input logic [W-1:0] edata, input logic cdata);
    vec_t v;
    v.dv = dv; v.pv = pv; v.rin = rin; v.dd = dd; v.pd = pd;
    v.edr = edr; v.epr = epr; v.ecnt = ecnt; v.evld = evld; v.edata = edata; v.cdata = cdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_vld  = 1'b0;
    m_data = '0;
    m_last = 1'b0;
    sb_q.delete();
  endtask

  // One cycle: drive after the falling edge, check before the rising edge, advance the model.
  task automatic step(input logic dv, input logic pv, input logic rin,
                      input logic [W-1:0] dd, input logic [W-1:0] pd);
    logic load, sel, e_d, e_p;
    @(negedge clk);
    dcp_vld_in = dv; per_vld_in = pv; pkt_rdy_in = rin;
    dcp_data_in = dd; per_data_in = pd;
    #1;
    load = !m_vld || rin;
    sel  = (dv && pv) ? !m_last : dv;
    e_d  = load && dv && sel;
    e_p  = load && pv && !sel;
    chk("m_dcp_rdy", W'(dcp_rdy_out), W'(e_d));
    chk("m_per_rdy", W'(per_rdy_out), W'(e_p));
    chk("m_cnt", W'(ptx_cnt_out), W'({e_d, e_p}));
    chk("m_rdy_excl", W'(dcp_rdy_out && per_rdy_out), W'(1'b0));
    chk("m_vld", W'(pkt_vld_out), W'(m_vld));
    chk("m_data", pkt_data_out, m_data);
    if (m_vld && rin) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_underflow: got packet %h expected none", pkt_data_out);
      end else begin
        chk("sb_data", pkt_data_out, sb_q.pop_front());
      end
    end
    if (e_d) begin
      sb_q.push_back(dd); m_data = dd; m_vld = 1'b1; m_last = 1'b1;
    end else if (e_p) begin
      sb_q.push_back(pd); m_data = pd; m_vld = 1'b1; m_last = 1'b0;
    end else if (rin) begin
      m_vld = 1'b0;
    end
  endtask

  initial begin
    // Single per beat, then six-cycle tie with output always ready, then drain.
    tbl[0]  = mk(1'b0, 1'b0, 1'b1, '0, '0,               1'b0, 1'b0, 2'b00, 1'b0, '0,        1'b1);
    tbl[1]  = mk(1'b0, 1'b1, 1'b1, '0, ppk(165),         1'b0, 1'b1, 2'b01, 1'b0, '0,        1'b1);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, '0, '0,               1'b0, 1'b0, 2'b00, 1'b1, ppk(165),  1'b1);
    tbl[3]  = mk(1'b1, 1'b1, 1'b1, dpk(3), ppk(3),       1'b1, 1'b0, 2'b10, 1'b0, '0,        1'b0);
    tbl[4]  = mk(1'b1, 1'b1, 1'b1, dpk(4), ppk(4),       1'b0, 1'b1, 2'b01, 1'b1, dpk(3),    1'b1);
    tbl[5]  = mk(1'b1, 1'b1, 1'b1, dpk(5), ppk(5),       1'b1, 1'b0, 2'b10, 1'b1, ppk(4),    1'b1);
    tbl[6]  = mk(1'b1, 1'b1, 1'b1, dpk(6), ppk(6),       1'b0, 1'b1, 2'b01, 1'b1, dpk(5),    1'b1);
    tbl[7]  = mk(1'b1, 1'b1, 1'b1, dpk(7), ppk(7),       1'b1, 1'b0, 2'b10, 1'b1, ppk(6),    1'b1);
    tbl[8]  = mk(1'b1, 1'b1, 1'b1, dpk(8), ppk(8),       1'b0, 1'b1, 2'b01, 1'b1, dpk(7),    1'b1);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, '0, '0,               1'b0, 1'b0, 2'b00, 1'b1, ppk(8),    1'b1);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, '0, '0,               1'b0, 1'b0, 2'b00, 1'b0, '0,        1'b0);

    // Reset state with both sources requesting
    dcp_vld_in = 1'b1; per_vld_in = 1'b1; pkt_rdy_in = 1'b1;
    dcp_data_in = dpk(255); per_data_in = ppk(255);
    #3;
    chk("rst_dcp_rdy", W'(dcp_rdy_out), W'(1'b0));
    chk("rst_per_rdy", W'(per_rdy_out), W'(1'b0));
    chk("rst_cnt", W'(ptx_cnt_out), W'(2'b00));
    chk("rst_vld", W'(pkt_vld_out), W'(1'b0));
    chk("rst_data", pkt_data_out, '0);
    dcp_vld_in = 1'b0; per_vld_in = 1'b0;
    model_reset();
    @(negedge clk);
    #2 reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].dv, tbl[i].pv, tbl[i].rin, tbl[i].dd, tbl[i].pd);
      chk($sformatf("tbl%0d_dcp_rdy", i), W'(dcp_rdy_out), W'(tbl[i].edr));
      chk($sformatf("tbl%0d_per_rdy", i), W'(per_rdy_out), W'(tbl[i].epr));
      chk($sformatf("tbl%0d_cnt", i), W'(ptx_cnt_out), W'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_vld", i), W'(pkt_vld_out), W'(tbl[i].evld));
      if (tbl[i].cdata) begin
        chk($sformatf("tbl%0d_data", i), pkt_data_out, tbl[i].edata);
      end
    end

    // Output stalled four cycles with both sources valid: one load, then held
    step(1'b1, 1'b1, 1'b0, dpk(50), ppk(50));
    chk("stall_first_cnt", W'(ptx_cnt_out), W'(2'b10));
    for (int k = 1; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b0, dpk(50 + k), ppk(50 + k));
      chk("stall_cnt", W'(ptx_cnt_out), W'(2'b00));
      chk("stall_rdy", W'(dcp_rdy_out || per_rdy_out), W'(1'b0));
      chk("stall_data", pkt_data_out, dpk(50));
      chk("stall_vld", W'(pkt_vld_out), W'(1'b1));
    end
    step(1'b0, 1'b0, 1'b1, '0, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0);

    // One-cycle dcp pulse during stall must not move last_src
    step(1'b0, 1'b1, 1'b0, '0, ppk(60));
    step(1'b1, 1'b0, 1'b0, dpk(61), '0);
    chk("pulse_cnt", W'(ptx_cnt_out), W'(2'b00));
    chk("pulse_dcp_rdy", W'(dcp_rdy_out), W'(1'b0));
    step(1'b1, 1'b1, 1'b1, dpk(62), ppk(62));
    chk("pulse_tie_dcp", W'(dcp_rdy_out), W'(1'b1));
    step(1'b0, 1'b0, 1'b1, '0, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0);

    // Toggling output ready with both sources valid
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, (k % 2 == 0) ? 1'b1 : 1'b0, dpk(100 + k), ppk(100 + k));
    end
    step(1'b0, 1'b0, 1'b1, '0, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0);

    // Asynchronous reset while a packet is held
    step(1'b1, 1'b1, 1'b0, dpk(70), ppk(70));
    @(posedge clk);
    #2;
    chk("pre_rst_vld", W'(pkt_vld_out), W'(1'b1));
    reset = 1'b1;
    #1;
    chk("arst_vld", W'(pkt_vld_out), W'(1'b0));
    chk("arst_data", pkt_data_out, '0);
    chk("arst_rdy", W'({dcp_rdy_out, per_rdy_out}), W'(2'b00));
    chk("arst_cnt", W'(ptx_cnt_out), W'(2'b00));
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    step(1'b1, 1'b1, 1'b1, dpk(71), ppk(71));
    chk("post_rst_tie_dcp", W'(dcp_rdy_out), W'(1'b1));
    step(1'b0, 1'b0, 1'b1, '0, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    chk("sb_empty", W'(sb_q.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
